// File: rtl/spi_initiator.sv
// Initiator for the single-wire serial memory link: serialises host requests and
// captures read replies. Define SPI_INIT_CS_EN to add a frame-enclosing cs_n output.
module spi_initiator #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              sout,
    input  logic              sin,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata
`ifdef SPI_INIT_CS_EN
    ,
    output logic              cs_n
`endif
);

    localparam int unsigned FRAME_W  = ADDR_W + DATA_W + 4;
    localparam int unsigned WR_END   = FRAME_W - 1;
    localparam int unsigned RD_END   = WR_END + RD_LAT;
    localparam int unsigned CNT_W    = $clog2(WR_END + 4);
    localparam int unsigned CMD_POS  = ADDR_W;
    localparam int unsigned TURN_END = ADDR_W + 2;
    localparam int unsigned DATA_BEG = ADDR_W + 3;
    localparam int unsigned DATA_END = ADDR_W + 2 + DATA_W;
    localparam int unsigned SMP_BEG  = DATA_BEG + RD_LAT;
    localparam int unsigned SMP_END  = DATA_END + RD_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_TURN,
        S_DATA,
        S_TAIL
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_last;
    logic               w_accept;
    logic               w_done;
    logic               w_sample;
    logic [DATA_W-1:0]  w_wdata_ld;

    logic [FRAME_W-1:0] r_frame;
    logic               r_we;
    logic [DATA_W-1:0]  r_shift;
    logic               r_busy;
    logic               r_ready;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
`ifdef SPI_INIT_CS_EN
    logic               r_cs_n;
`endif

    // Reads hold TAIL for RD_LAT extra slots so the last delayed bit can land.
    assign w_last     = r_we ? CNT_W'(WR_END) : CNT_W'(RD_END);
    assign w_wdata_ld = req_we ? req_wdata : DATA_W'(0);
    assign w_sample   = (r_state != S_IDLE) && !r_we &&
                        (r_cnt >= CNT_W'(SMP_BEG)) && (r_cnt <= CNT_W'(SMP_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            default: begin
                if ((r_state == S_TAIL) && (r_cnt == w_last)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_cnt_nxt < CNT_W'(CMD_POS)) begin
                        w_state_nxt = S_ADDR;
                    end else if (w_cnt_nxt == CNT_W'(CMD_POS)) begin
                        w_state_nxt = S_CMD;
                    end else if (w_cnt_nxt <= CNT_W'(TURN_END)) begin
                        w_state_nxt = S_TURN;
                    end else if (w_cnt_nxt <= CNT_W'(DATA_END)) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_TAIL;
                    end
                end
            end
        endcase
    end

    // Whole frame image is loaded at acceptance and shifted out MSB first; zeros fill behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame      <= '0;
            r_we         <= 1'b0;
            r_shift      <= '0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
`ifdef SPI_INIT_CS_EN
            r_cs_n       <= 1'b1;
`endif
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            r_ready      <= (w_state_nxt == S_IDLE);
            r_resp_valid <= w_done && !r_we;
`ifdef SPI_INIT_CS_EN
            r_cs_n       <= (w_state_nxt == S_IDLE);
`endif
            if (w_accept) begin
                r_we    <= req_we;
                r_frame <= {req_addr, req_we, 2'b00, w_wdata_ld, 1'b0};
            end else if (r_state != S_IDLE) begin
                r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            end
            if (w_sample) begin
                r_shift <= {r_shift[DATA_W-2:0], sin};
            end
            if (w_done && !r_we) begin
                r_resp_rdata <= r_shift;
            end
        end
    end

    assign sout       = r_frame[FRAME_W-1];
    assign busy       = r_busy;
    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
`ifdef SPI_INIT_CS_EN
    assign cs_n       = r_cs_n;
`endif

endmodule

// File: doc/spi_initiator.md
Name: spi_initiator

Overview:
- Initiator end of the single-wire serial memory-access link; drives frames into the serial responder/BRAM block and collects read data from it.
- Accepts one request at a time (address, write flag, write data) from a host-side valid/ready port.
- Serialises each request onto `sout`. For reads, samples the 16-bit reply on `sin` and returns it on a response strobe.
- Shares the responder's clock; there is no separate serial clock. One bit per `clk` cycle.

Parameters:
- ADDR_W, 5, address width in bits; sets the number of address slots per frame.
- DATA_W, 16, data word width in bits; sets the number of data slots per frame.
- RD_LAT, 1, cycles between the responder's data slot and the matching bit valid on `sin`; range 0..3.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request present.
- req_ready  output  1  initiator idle; request accepted on cycle with req_valid && req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target word address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- sout  output  1  serial bit to the responder's `din`.
- sin  input  1  serial bit from the responder's `dout`.
- busy  output  1  frame in progress.
- resp_valid  output  1  one-cycle pulse: read data valid.
- resp_rdata  output  DATA_W  captured read word; holds until the next read completes.

Behaviour:
- Reset values (async, immediate on rst_n low): sout=0, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, state=IDLE, bit counter=0. An in-flight frame is abandoned, and no partial response is issued.
- Acceptance: the request fields are latched into shadow registers on the handshake cycle. Host inputs are don't-care afterwards. The frame starts on the next cycle.
- Frame slots, one per cycle, using counter cnt 0..FRAME_END:
  - cnt 0..ADDR_W-1: ADDR state, sout = address MSB first.
  - cnt ADDR_W: CMD state, sout = we bit.
  - cnt ADDR_W+1..ADDR_W+2: TURN state, two turnaround slots, sout=0.
  - cnt ADDR_W+3..ADDR_W+2+DATA_W: DATA state.
    - Write: sout = wdata MSB first.
    - Read: sout=0.
  - TAIL state follows: one slot, sout=0. The responder commits writes here.
  - Reads extend TAIL by RD_LAT extra slots.
- Read sampling: the data bit for slot k is sampled from `sin` at slot k+RD_LAT. Bits shift into a DATA_W register MSB first.
- Read completion: on the cycle after the last sample, resp_rdata is updated and resp_valid=1 for exactly one cycle. The state returns to IDLE in the same cycle.
- Writes produce no response.
- Frame length (sample-to-sample defaults):
  - Write frame: 25 cycles, ADDR_W+DATA_W+4.
  - Read frame: 25+RD_LAT cycles.
- Back-to-back requests:
  - req_ready goes high again in the cycle the state enters IDLE.
  - A request accepted that cycle starts the next frame immediately, giving a minimum of one idle slot (sout=0) between frames.
- busy = (state != IDLE); req_ready = !busy.
- req_valid held low: the block stays in IDLE, sout=0, and no spurious strobes occur.
- Simultaneous events:
  - rst_n asserting in the same cycle as a handshake: reset wins, and the request is dropped.
  - resp_valid and a new request handshake may coincide.
- Widths: cnt is sized to hold FRAME_END+3. No arithmetic overflow is possible within the legal RD_LAT range.

Optional Feature:
- Macro: SPI_INIT_CS_EN.
- Defined: adds output `cs_n` (1 bit).
  - Reset value 1.
  - Driven 0 from the first ADDR slot through the last TAIL slot inclusive.
  - Returns to 1 for at least one cycle between frames.
- Not defined: the port is absent, and framing relies solely on the fixed slot count.

Test Plan:
- Write, addr=5'h13, wdata=16'hA5C3 -> sout sequence 1,0,0,1,1 | 1 | 0,0 | 1010010111000011 | 0. busy high 25 cycles. No resp_valid.
- Read, addr=5'h02; model drives 16'h1234 on sin with RD_LAT=1 -> single resp_valid pulse 26 cycles after the handshake, resp_rdata=16'h1234. sout=0 in all data slots.
- Write 16'hFFFF to addr 31, then a read of addr 31 held valid continuously -> second frame begins exactly one idle cycle after the first. Read returns 16'hFFFF. Address slots are all 1s.
- rst_n pulsed low at data slot 7 of a read -> sout=0, busy=0, req_ready=1 immediately. No resp_valid. resp_rdata keeps its prior value of 0.
- RD_LAT=3, read with sin returning 16'h8001 -> read frame 28 cycles, resp_rdata=16'h8001 (first and last bits captured correctly).
- With SPI_INIT_CS_EN: write frame -> cs_n low for exactly 25 cycles and high in the idle gap. Without the macro, the build has no cs_n port.
